// File: rtl/ppu_id_ex_stage_if.sv
// ID/EX boundary signal bundle.
// master drives the ID side, slave is the stage.
interface ppu_id_ex_stage_if #(
  parameter int CTRL_W = 22,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [4:0]        id_dest;
  logic              id_is_load;
  logic              ex_branch_taken;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [4:0]        ex_dest;
  logic              ex_is_load;
  logic              stall;
  logic              flush_ifid;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output id_valid, id_ctrl, id_rs, id_rt,
    output id_uses_rs, id_uses_rt, id_dest,
    output id_is_load, ex_branch_taken,
    input  ex_valid, ex_ctrl, ex_dest,
    input  ex_is_load, stall, flush_ifid,
    input  bubble_count
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs, id_rt,
    input  id_uses_rs, id_uses_rt, id_dest,
    input  id_is_load, ex_branch_taken,
    output ex_valid, ex_ctrl, ex_dest,
    output ex_is_load, stall, flush_ifid,
    output bubble_count
  );
endinterface

// File: rtl/ppu_id_ex_stage.sv
// ID/EX pipeline register with load-use stall,
// branch squash and bubble counter.
module ppu_id_ex_stage #(
  parameter int CTRL_W      = 22,
  parameter int LOAD_LAT    = 1,
  parameter int DELAY_SLOTS = 1,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              reset,
  ppu_id_ex_stage_if.slave bus
);

  typedef enum logic {RUN, STALL} state_e;

  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [4:0]        ex_dest_q, ex_dest_d;
  logic              ex_is_load_q, ex_is_load_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;

  logic squash;
  logic hazard;
  logic rs_hit;
  logic rt_hit;
  logic advance;
  logic bubble_en;
  logic stall;

  // Squash and load-use hazard detection.
  always_comb begin
    squash = bus.ex_branch_taken
           && (DELAY_SLOTS == 0);
    rs_hit = bus.id_uses_rs
           && (bus.id_rs == ex_dest_q);
    rt_hit = bus.id_uses_rt
           && (bus.id_rt == ex_dest_q);
    hazard = (state_q == RUN)
           && bus.id_valid
           && ex_valid_q
           && ex_is_load_q
           && (ex_dest_q != 5'd0)
           && (rs_hit || rt_hit);
  end

  // Next state, stall and bubble control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    advance   = 1'b0;
    bubble_en = 1'b0;
    if (squash) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hazard) begin
            stall     = 1'b1;
            bubble_en = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              cnt_d   = LAT_M1;
            end
          end else begin
            advance = 1'b1;
          end
        end
        STALL: begin
          stall     = 1'b1;
          bubble_en = 1'b1;
          cnt_d     = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // EX payload: copy ID on advance, else bubble.
  always_comb begin
    ex_valid_d   = 1'b0;
    ex_ctrl_d    = '0;
    ex_dest_d    = 5'd0;
    ex_is_load_d = 1'b0;
    if (advance && bus.id_valid) begin
      ex_valid_d   = 1'b1;
      ex_ctrl_d    = bus.id_ctrl;
      ex_dest_d    = bus.id_dest;
      ex_is_load_d = bus.id_is_load;
    end
  end

  // Saturating hazard bubble counter.
  always_comb begin
    bcnt_d = bcnt_q;
    if (bubble_en && !(&bcnt_q)) begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= 2'd0;
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_dest_q    <= 5'd0;
      ex_is_load_q <= 1'b0;
      bcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_dest_q    <= ex_dest_d;
      ex_is_load_q <= ex_is_load_d;
      bcnt_q       <= bcnt_d;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_ctrl      = ex_ctrl_q;
  assign bus.ex_dest      = ex_dest_q;
  assign bus.ex_is_load   = ex_is_load_q;
  assign bus.stall        = stall;
  assign bus.flush_ifid   = squash;
  assign bus.bubble_count = bcnt_q;

endmodule

// File: tb/tb_ppu_id_ex_stage.sv
// Bench for ppu_id_ex_stage: three configurations
// driven in lockstep against a cycle-level model.
module tb_ppu_id_ex_stage;

  localparam int CW = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [CW-1:0] id_ctrl;
  logic [4:0]    id_rs, id_rt, id_dest;
  logic          id_uses_rs, id_uses_rt;
  logic          id_is_load;
  logic          bt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ppu_id_ex_stage_if #(.CTRL_W(CW), .CNT_W(16)) if0 ();
  ppu_id_ex_stage_if #(.CTRL_W(CW), .CNT_W(16)) if1 ();
  ppu_id_ex_stage_if #(.CTRL_W(CW), .CNT_W(2))  if2 ();

  `define TB_DRV(I) \
    assign I.id_valid = id_valid; \
    assign I.id_ctrl = id_ctrl; \
    assign I.id_rs = id_rs; \
    assign I.id_rt = id_rt; \
    assign I.id_uses_rs = id_uses_rs; \
    assign I.id_uses_rt = id_uses_rt; \
    assign I.id_dest = id_dest; \
    assign I.id_is_load = id_is_load; \
    assign I.ex_branch_taken = bt;

  `TB_DRV(if0)
  `TB_DRV(if1)
  `TB_DRV(if2)

  ppu_id_ex_stage #(
    .CTRL_W(CW), .LOAD_LAT(1),
    .DELAY_SLOTS(1), .CNT_W(16)
  ) u0 (.clk(clk), .reset(reset), .bus(if0));

  ppu_id_ex_stage #(
    .CTRL_W(CW), .LOAD_LAT(3),
    .DELAY_SLOTS(0), .CNT_W(16)
  ) u1 (.clk(clk), .reset(reset), .bus(if1));

  ppu_id_ex_stage #(
    .CTRL_W(CW), .LOAD_LAT(2),
    .DELAY_SLOTS(0), .CNT_W(2)
  ) u2 (.clk(clk), .reset(reset), .bus(if2));

  logic          o_valid[3];
  logic [CW-1:0] o_ctrl[3];
  logic [4:0]    o_dest[3];
  logic          o_load[3];
  logic          o_stall[3];
  logic          o_flush[3];
  logic [15:0]   o_cnt[3];

  assign o_valid[0] = if0.ex_valid;
  assign o_valid[1] = if1.ex_valid;
  assign o_valid[2] = if2.ex_valid;
  assign o_ctrl[0]  = if0.ex_ctrl;
  assign o_ctrl[1]  = if1.ex_ctrl;
  assign o_ctrl[2]  = if2.ex_ctrl;
  assign o_dest[0]  = if0.ex_dest;
  assign o_dest[1]  = if1.ex_dest;
  assign o_dest[2]  = if2.ex_dest;
  assign o_load[0]  = if0.ex_is_load;
  assign o_load[1]  = if1.ex_is_load;
  assign o_load[2]  = if2.ex_is_load;
  assign o_stall[0] = if0.stall;
  assign o_stall[1] = if1.stall;
  assign o_stall[2] = if2.stall;
  assign o_flush[0] = if0.flush_ifid;
  assign o_flush[1] = if1.flush_ifid;
  assign o_flush[2] = if2.flush_ifid;
  assign o_cnt[0]   = if0.bubble_count;
  assign o_cnt[1]   = if1.bubble_count;
  assign o_cnt[2]   = 16'(if2.bubble_count);

  // Configuration of each DUT as seen by the model.
  int lat[3]  = '{1, 3, 2};
  int ds[3]   = '{1, 0, 0};
  int cmax[3] = '{65535, 65535, 3};

  // Model: what EX holds and how many stall
  // cycles are still owed after this one.
  bit          m_valid[3];
  bit [CW-1:0] m_ctrl[3];
  bit [4:0]    m_dest[3];
  bit          m_load[3];
  int          m_left[3];
  int          m_cnt[3];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 0;
      m_ctrl[k]  = '0;
      m_dest[k]  = '0;
      m_load[k]  = 0;
      m_left[k]  = 0;
      m_cnt[k]   = 0;
    end
  endtask

  function automatic bit m_squash(int k);
    return bt && ds[k] == 0;
  endfunction

  function automatic bit m_hazard(int k);
    bit reads;
    reads = (id_uses_rs && id_rs == m_dest[k])
         || (id_uses_rt && id_rt == m_dest[k]);
    return m_left[k] == 0 && id_valid
        && m_valid[k] && m_load[k]
        && m_dest[k] != 0 && reads;
  endfunction

  task automatic m_bubble(int k, bit counted);
    m_valid[k] = 0;
    m_ctrl[k]  = '0;
    m_dest[k]  = '0;
    m_load[k]  = 0;
    if (counted && m_cnt[k] < cmax[k])
      m_cnt[k]++;
  endtask

  task automatic m_clock();
    for (int k = 0; k < 3; k++) begin
      if (m_squash(k)) begin
        m_bubble(k, 0);
        m_left[k] = 0;
      end else if (m_left[k] > 0) begin
        m_bubble(k, 1);
        m_left[k]--;
      end else if (m_hazard(k)) begin
        m_bubble(k, 1);
        m_left[k] = lat[k] - 1;
      end else if (id_valid) begin
        m_valid[k] = 1;
        m_ctrl[k]  = id_ctrl;
        m_dest[k]  = id_dest;
        m_load[k]  = id_is_load;
      end else begin
        m_bubble(k, 0);
      end
    end
  endtask

  task automatic chk_comb();
    bit sq, st;
    for (int k = 0; k < 3; k++) begin
      sq = m_squash(k);
      st = !sq && (m_left[k] > 0 || m_hazard(k));
      chk($sformatf("u%0d.stall", k),
          32'(o_stall[k]), 32'(st));
      chk($sformatf("u%0d.flush", k),
          32'(o_flush[k]), 32'(sq));
    end
  endtask

  task automatic chk_regs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.valid", k),
          32'(o_valid[k]), 32'(m_valid[k]));
      chk($sformatf("u%0d.ctrl", k),
          32'(o_ctrl[k]), 32'(m_ctrl[k]));
      chk($sformatf("u%0d.dest", k),
          32'(o_dest[k]), 32'(m_dest[k]));
      chk($sformatf("u%0d.load", k),
          32'(o_load[k]), 32'(m_load[k]));
      chk($sformatf("u%0d.bcnt", k),
          32'(o_cnt[k]), 32'(m_cnt[k]));
    end
  endtask

  // Inputs are set just after a falling edge.
  task automatic step();
    #1;
    chk_comb();
    @(posedge clk);
    m_clock();
    @(negedge clk);
    chk_regs();
  endtask

  task automatic set_id(
    input bit       v,
    input bit [4:0] rs, input bit urs,
    input bit [4:0] rt, input bit urt,
    input bit [4:0] dst, input bit ld
  );
    id_valid   = v;
    id_ctrl    = CW'($urandom);
    id_rs      = rs;
    id_uses_rs = urs;
    id_rt      = rt;
    id_uses_rt = urt;
    id_dest    = dst;
    id_is_load = ld;
    bt         = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, ".valid"}, 32'(o_valid[k]), 0);
      chk({tag, ".ctrl"},  32'(o_ctrl[k]), 0);
      chk({tag, ".stall"}, 32'(o_stall[k]), 0);
      chk({tag, ".bcnt"},  32'(o_cnt[k]), 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    id_ctrl = '0;
    m_reset();
    #7;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    // Basic latency
    set_id(1, 1, 1, 2, 1, 3, 0);
    id_ctrl = 22'h0C1234;
    step();
    chk("lat.ctrl", 32'(o_ctrl[0]), 32'h0C1234);

    // Load-use on rs, held for 4 cycles
    set_id(1, 0, 0, 0, 0, 5, 1);
    step();
    set_id(1, 5, 1, 9, 0, 7, 0);
    repeat (4) step();
    chk("lu1.bcnt", 32'(o_cnt[0]), 1);
    chk("lu3.bcnt", 32'(o_cnt[1]), 3);

    // rt match but not used
    set_id(1, 0, 0, 0, 0, 5, 1);
    step();
    set_id(1, 1, 1, 5, 0, 8, 0);
    step();

    // Load into $0
    set_id(1, 0, 0, 0, 0, 0, 1);
    step();
    set_id(1, 0, 1, 0, 1, 4, 0);
    step();

    // Taken branch with valid ID
    set_id(1, 2, 1, 3, 1, 6, 0);
    bt = 1'b1;
    step();
    set_id(0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset in the middle of a stall
    set_id(1, 0, 0, 0, 0, 5, 1);
    step();
    set_id(1, 5, 1, 0, 0, 7, 0);
    step();
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    chk_zero("mrst");
    @(negedge clk);
    reset = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    step();

    // Repeated hazards for saturation
    for (int i = 0; i < 5; i++) begin
      set_id(1, 0, 0, 0, 0, 6, 1);
      step();
      set_id(1, 0, 0, 6, 1, 2, 0);
      repeat (3) step();
    end
    chk("sat.bcnt", 32'(o_cnt[2]), 3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      set_id(
        $urandom_range(0, 7) != 0,
        5'($urandom_range(0, 3)),
        1'($urandom),
        5'($urandom_range(0, 3)),
        1'($urandom),
        5'($urandom_range(0, 3)),
        $urandom_range(0, 2) == 0);
      bt = $urandom_range(0, 9) == 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ppu_id_ex_stage.md
# ppu_id_ex_stage

Registered ID/EX boundary for the PPU pipeline. It latches the packed control vector produced by the decode-stage control unit, together with the destination and load flag, into the EX stage. It detects load-use hazards against the instruction in EX and stalls ID/IF for a parametrised number of cycles while inserting bubbles. It also squashes the ID instruction on a taken branch/jump when no delay slot is configured, and counts hazard bubbles for performance monitoring.

## Interface
Parameters:
- CTRL_W, 22, width of packed control vector (all-zero vector is a NOP)
- LOAD_LAT, 1, stall cycles per load-use hazard (legal 1..3)
- DELAY_SLOTS, 1, 1 = instruction in ID at branch resolution executes; 0 = it is squashed
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  CTRL_W  control vector from decoder
- id_rs, id_rt  in  5 each  source register numbers
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads that source
- id_dest  in  5  resolved destination register (rd/rt/31)
- id_is_load  in  1  instruction is a memory load
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  CTRL_W  registered control vector
- ex_dest  out  5  registered destination
- ex_is_load  out  1  registered load flag
- stall  out  1  hold PC and IF/ID register (combinational)
- flush_ifid  out  1  kill IF/ID contents (combinational)
- bubble_count  out  CNT_W  saturating count of hazard bubbles

## Operation
- FSM states: RUN, STALL; internal counter cnt (2 bits).
- hazard = state==RUN & id_valid & ex_valid & ex_is_load & ex_dest!=0 & ((id_uses_rs & id_rs==ex_dest) | (id_uses_rt & id_rt==ex_dest)).
- squash = ex_branch_taken & DELAY_SLOTS==0.
- Priority per cycle: squash > hazard > normal advance.
- Normal advance (RUN, no hazard, no squash): ex_* <= id_* ; ex_valid <= id_valid.
- Bubble (hazard, STALL, squash, or id_valid=0): ex_valid<=0, ex_ctrl<=0, ex_dest<=0, ex_is_load<=0.
- RUN & hazard: bubble, stall=1; if LOAD_LAT>1 go STALL with cnt<=LOAD_LAT-1, else stay RUN.
- STALL: bubble, stall=1, cnt<=cnt-1; when cnt==1 go RUN. Total stall per hazard = LOAD_LAT cycles exactly.
- squash: bubble, stall=0, flush_ifid=1, next state RUN (aborts any pending STALL).
- DELAY_SLOTS==1: ex_branch_taken has no effect; flush_ifid=0 always.
- bubble_count increments by 1 on every hazard/STALL bubble cycle (not squash, not id_valid=0); saturates at all-ones.
- Register 0 never creates a hazard.

## Timing
- Reset (async, immediate): all ex_* outputs 0, bubble_count 0, state RUN, cnt 0; therefore stall=0, flush_ifid=0 while reset is held.
- Latency ID->EX: 1 cycle.
- stall and flush_ifid are combinational from current state, registered ex_* and current inputs; valid within the same cycle.
- Reset mid-STALL: returns to RUN, pending stall cycles discarded.
- ex_branch_taken during STALL cannot occur legally (EX holds a bubble); with DELAY_SLOTS==0 it still squashes.

## Test plan
- Reset: assert reset mid-cycle with ex_valid=1 -> all outputs 0 immediately; after release, id_ctrl=22'h0C1234, id_valid=1 -> ex_ctrl=22'h0C1234 one cycle later.
- Load-use, LOAD_LAT=1: EX holds load ex_dest=5, ID reads rs=5 -> stall=1 one cycle, one bubble, bubble_count=1, then ID instruction reaches EX.
- LOAD_LAT=3, same hazard -> stall high exactly 3 cycles, 3 bubbles, bubble_count=3; ID reads rt=5 with id_uses_rt=0 -> no stall.
- Load into $0 with ID rs=0 -> no stall, bubble_count unchanged.
- DELAY_SLOTS=0, ex_branch_taken=1 with valid ID -> flush_ifid=1, ex_valid=0 next cycle, bubble_count unchanged; DELAY_SLOTS=1 -> ID instruction enters EX.
- CNT_W=2, five hazard bubbles -> bubble_count saturates at 3.
